pipe_hazard_ctrl: RTL

- Generates the per-stage write enables and bubble (flush) controls for the 5-stage pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Each flush output is the clear control for its pipeline register. A flush with wr_en=1 makes that register load all-zero control bits, i.e. a bubble.
- Handles three conditions:
  - load-use stalls;
  - taken-branch squashes;
  - whole-pipeline freezes while data memory is busy.
- A branch that resolves during a freeze is remembered and applied when the freeze releases.
- Two saturating counters record stall and flush activity for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: per-stage write enables, bubble
// controls, a deferred branch squash across memory freezes, and perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int XZR   = 31,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic             id_uses_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             br_taken,
  input  logic             dmem_busy,
  output logic             pc_wr_en,
  output logic             if_id_wr_en,
  output logic             id_ex_wr_en,
  output logic             ex_mem_wr_en,
  output logic             mem_wb_wr_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN = 1'b0, FREEZE = 1'b1} state_t;

  localparam logic [REG_W-1:0] ZERO_REG = REG_W'(XZR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t state;
  logic   pend_flush;
  logic   lu_hz;
  logic   br_eff;

  assign lu_hz = ex_mem_read && (ex_rd != ZERO_REG) &&
                 ((id_uses_rn && (id_rn == ex_rd)) ||
                  (id_uses_rm && (id_rm == ex_rd)));
  assign br_eff = br_taken | pend_flush;

  // A busy MEM stage freezes everything in either state; on release the
  // FREEZE state behaves exactly like RUN, with a remembered branch folded in.
  always_comb begin
    pc_wr_en     = 1'b0;
    if_id_wr_en  = 1'b0;
    id_ex_wr_en  = 1'b0;
    ex_mem_wr_en = 1'b0;
    mem_wb_wr_en = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (!reset && !dmem_busy) begin
      id_ex_wr_en  = 1'b1;
      ex_mem_wr_en = 1'b1;
      mem_wb_wr_en = 1'b1;
      if (br_eff) begin
        pc_wr_en    = 1'b1;
        if_id_wr_en = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu_hz) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_wr_en    = 1'b1;
        if_id_wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pend_flush   <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_busy) begin
            state      <= FREEZE;
            pend_flush <= br_taken;
          end else if (br_eff) begin
            pend_flush <= 1'b0;
          end
        end
        FREEZE: begin
          if (dmem_busy) begin
            pend_flush <= pend_flush | br_taken;
          end else begin
            state <= RUN;
            if (br_eff) pend_flush <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
      if (!pc_wr_en && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (if_id_flush && id_ex_flush && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
